// File: rtl/row_scoring_controller.sv
// row_scoring_controller
// Owns the 6x5 Wordle board. Captures letters written to the active row
// while editing. On a submit pulse it scores the row against the answer
// (five green cycles, five yellow cycles, one commit cycle). It then
// advances to the next row or ends the game.
//
// Ports:
//   clk            in   system clock, rising edge
//   clr            in   synchronous active-high reset
//   columnIn[2:0]  in   active column 0..4; larger values suppress the write
//   valueIn[6:0]   in   [6:5] colour (ignored), [4:0] letter (A=0..Z=25, blank=26)
//   submitted      in   single-cycle pulse: active row complete
//   answer[24:0]   in   target word, letter k at [5k+4:5k]
//   rowValuesFlat  out  active row entries, column k at [7k+6:7k]
//   boardFlat      out  full board, row r col k at [35r+7k+6:35r+7k]
//   currentRow     out  active row index
//   busy           out  high while scoring
//   doneGame       out  game over
//   won            out  valid when doneGame=1
module row_scoring_controller (
    input  logic         clk,
    input  logic         clr,
    input  logic [2:0]   columnIn,
    input  logic [6:0]   valueIn,
    input  logic         submitted,
    input  logic [24:0]  answer,
    output logic [34:0]  rowValuesFlat,
    output logic [209:0] boardFlat,
    output logic [2:0]   currentRow,
    output logic         busy,
    output logic         doneGame,
    output logic         won
);
    localparam int unsigned ROWS    = 6;
    localparam int unsigned COLS    = 5;
    localparam int unsigned LW      = 5;
    localparam int unsigned EW      = 7;
    localparam logic [4:0]  BLANK   = 5'd26;
    localparam logic [1:0]  C_GREY  = 2'd0;
    localparam logic [1:0]  C_YEL   = 2'd1;
    localparam logic [1:0]  C_GREEN = 2'd2;

    typedef enum logic [2:0] {
        EDIT   = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [EW-1:0] board      [ROWS][COLS];
    logic [EW-1:0] row_values [COLS];
    logic [LW-1:0] guess      [COLS];
    logic [LW-1:0] ans        [COLS];
    logic [1:0]    colour     [COLS];
    logic [COLS-1:0] used;
    logic [2:0]    idx;
    logic [2:0]    current_row;
    logic          done_game;
    logic          won_q;

    // The colour field of valueIn is never stored.
    logic unused_colour_in;
    assign unused_colour_in = ^valueIn[6:5];

    logic          col_valid;
    logic [EW-1:0] wr_entry;
    assign col_valid = (columnIn < 3'(COLS));
    assign wr_entry  = {2'b00, valueIn[4:0]};

    // Active row as it will look after this cycle's write; latched on submit.
    logic [LW-1:0] row_next [COLS];
    always_comb begin
        for (int k = 0; k < COLS; k++) begin
            row_next[k] = board[current_row][k][LW-1:0];
            if (col_valid && (columnIn == 3'(k)))
                row_next[k] = valueIn[4:0];
        end
    end

    // Lowest unused answer position matching the current guess letter.
    logic [LW-1:0] guess_cur;
    logic          yel_hit;
    logic [2:0]    yel_j;
    assign guess_cur = guess[idx];
    always_comb begin
        yel_hit = 1'b0;
        yel_j   = 3'd0;
        for (int j = COLS - 1; j >= 0; j--) begin
            if (!used[j] && (ans[j] == guess_cur)) begin
                yel_hit = 1'b1;
                yel_j   = 3'(j);
            end
        end
    end

    logic all_green;
    always_comb begin
        all_green = 1'b1;
        for (int k = 0; k < COLS; k++)
            if (colour[k] != C_GREEN) all_green = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) state <= EDIT;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            EDIT:   if (submitted) state_next = GREEN;
            GREEN:  if (idx == 3'(COLS - 1)) state_next = YELLOW;
            YELLOW: if (idx == 3'(COLS - 1)) state_next = COMMIT;
            COMMIT: begin
                if (all_green || (current_row == 3'(ROWS - 1))) state_next = DONE;
                else                                             state_next = EDIT;
            end
            DONE:   state_next = DONE;
            default: state_next = EDIT;
        endcase
    end

    // Board, scoring datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < COLS; k++)
                    board[r][k] <= {2'b00, BLANK};
            for (int k = 0; k < COLS; k++) begin
                row_values[k] <= {2'b00, BLANK};
                guess[k]      <= BLANK;
                ans[k]        <= '0;
                colour[k]     <= C_GREY;
            end
            used        <= '0;
            idx         <= '0;
            current_row <= '0;
            busy        <= 1'b0;
            done_game   <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            busy <= (state_next == GREEN) || (state_next == YELLOW) ||
                    (state_next == COMMIT);
            case (state)
                EDIT: begin
                    if (col_valid) begin
                        board[current_row][columnIn] <= wr_entry;
                        row_values[columnIn]         <= wr_entry;
                    end
                    if (submitted) begin
                        for (int k = 0; k < COLS; k++) begin
                            guess[k]  <= row_next[k];
                            ans[k]    <= answer[LW*k +: LW];
                            colour[k] <= C_GREY;
                        end
                        used <= '0;
                        idx  <= '0;
                    end
                end
                GREEN: begin
                    if ((guess[idx] == ans[idx]) && (guess[idx] < BLANK)) begin
                        colour[idx] <= C_GREEN;
                        used[idx]   <= 1'b1;
                    end else begin
                        colour[idx] <= C_GREY;
                    end
                    idx <= (idx == 3'(COLS - 1)) ? 3'd0 : idx + 3'd1;
                end
                YELLOW: begin
                    if ((colour[idx] != C_GREEN) && (guess_cur < BLANK) && yel_hit) begin
                        colour[idx] <= C_YEL;
                        used[yel_j] <= 1'b1;
                    end
                    idx <= (idx == 3'(COLS - 1)) ? 3'd0 : idx + 3'd1;
                end
                COMMIT: begin
                    for (int k = 0; k < COLS; k++)
                        board[current_row][k] <= {colour[k], guess[k]};
                    if (all_green || (current_row == 3'(ROWS - 1))) begin
                        done_game <= 1'b1;
                        won_q     <= all_green;
                        for (int k = 0; k < COLS; k++)
                            row_values[k] <= {colour[k], guess[k]};
                    end else begin
                        current_row <= current_row + 3'd1;
                        // Rows beyond the active one are never written, so blank.
                        for (int k = 0; k < COLS; k++)
                            row_values[k] <= board[current_row + 3'd1][k];
                    end
                end
                default: ;
            endcase
        end
    end

    // Flatten registered storage onto the output buses.
    always_comb begin
        boardFlat = '0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                boardFlat[35*r + EW*k +: EW] = board[r][k];
    end

    always_comb begin
        rowValuesFlat = '0;
        for (int k = 0; k < COLS; k++)
            rowValuesFlat[EW*k +: EW] = row_values[k];
    end

    assign currentRow = current_row;
    assign doneGame   = done_game;
    assign won        = won_q;

endmodule

// File: tb/tb_row_scoring_controller.sv
// Directed bench for row_scoring_controller with hand-computed expectations.
module tb_row_scoring_controller;
    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic [2:0]   columnIn = 3'd7;
    logic [6:0]   valueIn = '0;
    logic         submitted = 1'b0;
    logic [24:0]  answer = '0;
    logic [34:0]  rowValuesFlat;
    logic [209:0] boardFlat;
    logic [2:0]   currentRow;
    logic         busy;
    logic         doneGame;
    logic         won;

    int checks   = 0;
    int failures = 0;

    row_scoring_controller dut (
        .clk(clk), .clr(clr), .columnIn(columnIn), .valueIn(valueIn),
        .submitted(submitted), .answer(answer), .rowValuesFlat(rowValuesFlat),
        .boardFlat(boardFlat), .currentRow(currentRow), .busy(busy),
        .doneGame(doneGame), .won(won)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [209:0] got, input logic [209:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] w5(input int a, input int b, input int c, input int d, input int e);
        return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    // Row built from a word and per-column colours.
    function automatic logic [34:0] mk_row(input logic [24:0] wd, input logic [9:0] cols);
        logic [34:0] r;
        for (int k = 0; k < 5; k++) r[7*k +: 7] = {cols[2*k +: 2], wd[5*k +: 5]};
        return r;
    endfunction

    function automatic logic [209:0] blank_board();
        logic [209:0] b;
        for (int i = 0; i < 30; i++) b[7*i +: 7] = 7'd26;
        return b;
    endfunction

    task automatic do_reset();
        clr = 1'b1; submitted = 1'b0; columnIn = 3'd7;
        tick();
        clr = 1'b0;
    endtask

    // Enter five letters with submit on column 4; returns at cycle T+1.
    task automatic enter_row(input logic [24:0] wd, input logic [1:0] cbits);
        for (int c = 0; c < 5; c++) begin
            columnIn  = 3'(c);
            valueIn   = {cbits, wd[5*c +: 5]};
            submitted = (c == 4);
            tick();
        end
        submitted = 1'b0;
        columnIn  = 3'd7;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    localparam logic [9:0] ALL_GREEN = 10'b10_10_10_10_10;

    logic [24:0]  crane, apple, papal, zzzzz, slate;
    logic [209:0] exp_b, snap;
    logic [13:0]  busy_trace, busy_exp;
    int n;

    initial begin
        crane = w5(2, 17, 0, 13, 4);
        apple = w5(0, 15, 15, 11, 4);
        papal = w5(15, 0, 15, 0, 11);
        zzzzz = w5(25, 25, 25, 25, 25);
        slate = w5(18, 11, 0, 19, 4);

        // Reset state
        do_reset();
        check("rst_board", boardFlat, blank_board());
        check("rst_row", 210'(rowValuesFlat), 210'({5{7'd26}}));
        check("rst_flags", 210'({currentRow, busy, doneGame, won}), 210'(6'd0));

        // Out-of-range column write suppressed; in-range write visible next cycle
        columnIn = 3'd5; valueIn = 7'd3; tick();
        check("col5_suppressed", boardFlat, blank_board());
        columnIn = 3'd1; valueIn = 7'h67; tick();
        columnIn = 3'd7;
        check("edit_write", 210'(rowValuesFlat), 210'({{3{7'd26}}, 7'd7, 7'd26}));

        // Win on row 0; answer changed mid-scoring must not matter
        do_reset();
        answer = crane;
        enter_row(crane, 2'b00);
        answer = zzzzz;
        count_busy(n);
        check("win_busy_len", 210'(n), 210'(11));
        exp_b = blank_board();
        exp_b[34:0] = mk_row(crane, ALL_GREEN);
        check("win_board", boardFlat, exp_b);
        check("win_rowvals", 210'(rowValuesFlat), 210'(mk_row(crane, ALL_GREEN)));
        check("win_flags", 210'({currentRow, doneGame, won}), 210'({3'd0, 1'b1, 1'b1}));

        // Duplicate letters; colour bits on valueIn are discarded
        do_reset();
        answer = apple;
        enter_row(papal, 2'b11);
        count_busy(n);
        exp_b = blank_board();
        exp_b[34:0] = mk_row(papal, 10'b01_00_10_01_01);
        check("dup_board", boardFlat, exp_b);
        check("dup_flags", 210'({currentRow, doneGame, won}), 210'({3'd1, 1'b0, 1'b0}));
        check("dup_rowvals_next", 210'(rowValuesFlat), 210'({5{7'd26}}));

        // Loss after six rows, then board frozen
        do_reset();
        answer = crane;
        for (int r = 0; r < 6; r++) begin
            enter_row(zzzzz, 2'b00);
            count_busy(n);
        end
        exp_b = '0;
        for (int i = 0; i < 30; i++) exp_b[7*i +: 7] = 7'd25;
        check("loss_board", boardFlat, exp_b);
        check("loss_flags", 210'({currentRow, doneGame, won, busy}), 210'({3'd5, 1'b1, 1'b0, 1'b0}));
        snap = exp_b;
        columnIn = 3'd0; valueIn = 7'd2; submitted = 1'b1; tick();
        submitted = 1'b0; columnIn = 3'd3; tick(); tick();
        columnIn = 3'd7;
        check("done_frozen", boardFlat, snap);
        check("done_rowvals", 210'(rowValuesFlat), 210'({5{7'd25}}));
        check("done_busy", 210'({busy, doneGame}), 210'(2'b01));

        // Busy lockout: second submit and write at T+3 ignored
        do_reset();
        answer = crane;
        enter_row(slate, 2'b00);
        busy_trace = '0;
        for (int c = 1; c <= 14; c++) begin
            busy_trace[c-1] = busy;
            if (c == 3) begin
                submitted = 1'b1; columnIn = 3'd0; valueIn = 7'd25;
            end
            tick();
            submitted = 1'b0; columnIn = 3'd7;
        end
        busy_exp = 14'b00_0111_1111_1111;
        check("lock_busy_trace", 210'(busy_trace), 210'(busy_exp));
        exp_b = blank_board();
        exp_b[34:0] = mk_row(slate, 10'b10_00_10_00_00);
        check("lock_board", boardFlat, exp_b);
        check("lock_flags", 210'({currentRow, doneGame}), 210'({3'd1, 1'b0}));

        // Reset during YELLOW
        do_reset();
        answer = crane;
        enter_row(crane, 2'b00);
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) clr = 1'b1;
            tick();
        end
        clr = 1'b0;
        check("midrst_board", boardFlat, blank_board());
        check("midrst_flags", 210'({currentRow, busy, doneGame, won}), 210'(6'd0));
        columnIn = 3'd4; valueIn = 7'd9; tick();
        columnIn = 3'd7; tick();
        check("midrst_edit", 210'({rowValuesFlat, busy}), 210'({7'd9, {4{7'd26}}, 1'b0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/row_scoring_controller.md
# row_scoring_controller

Game-sequencing controller that owns the 6×5 Wordle board and sits between the cursor/selection datapath and the display. It captures letters as the player edits the active row and feeds the stored row back. On a submit pulse it scores the row against the answer over a fixed multi-cycle sequence, writes the colours back, then either advances to the next row or ends the game.

## Interface
- ROWS, 6, number of guess rows; row index width is 3 bits.
- COLS, 5, letters per row; fixed, not configurable.
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- columnIn  in  3  active column from the selection datapath, 0..4.
- valueIn  in  7  active entry: [6:5] colour, [4:0] letter (A=0 … Z=25, blank=26).
- submitted  in  1  single-cycle pulse; the active row is complete.
- answer  in  25  target word; letter k at [5k+4:5k].
- rowValuesFlat  out  35  active-row entries; column k at [7k+6:7k].
- boardFlat  out  210  full board; row r, column k at [35r+7k+6:35r+7k].
- currentRow  out  3  active row index.
- busy  out  1  high while scoring.
- doneGame  out  1  game over (win or rows exhausted).
- won  out  1  valid when doneGame=1.

## Operation
- Colour codes: grey=0, yellow=1, green=2, red=3. Stored board entries only ever hold grey, yellow or green.
- **Reset:**
  - Every board entry becomes letter 26, colour 0 (value 7'd26).
  - currentRow=0; busy, doneGame and won are 0; state is EDIT.
- **EDIT:**
  - Each cycle, board[currentRow][columnIn] ← {2'b00, valueIn[4:0]}.
  - A columnIn value above 4 suppresses the write.
  - If submitted=1, the write for that cycle still occurs. The row (including that write) and answer are latched into guess/answer registers, and the state moves to GREEN.
- **GREEN:**
  - Index i runs 0→4, one column per cycle.
  - If guess[i]==answer[i] and guess[i]<26: colour[i]=green and used[i]=1. Otherwise colour[i]=grey.
  - After i=4, go to YELLOW.
- **YELLOW:**
  - Index i runs 0→4, one column per cycle.
  - If colour[i]≠green and guess[i]<26, find the lowest j with used[j]=0 and answer[j]==guess[i].
  - If such a j exists: colour[i]=yellow and used[j]=1.
  - After i=4, go to COMMIT.
- **COMMIT (1 cycle):**
  - board[currentRow][k] ← {colour[k], guess[k]} for all k.
  - If all five colours are green: won←1, doneGame←1, state DONE.
  - Else if currentRow==ROWS-1: won←0, doneGame←1, state DONE.
  - Else currentRow←currentRow+1, state EDIT.
- **DONE:** board frozen; writes and submitted are ignored until clr.
- **Ignored inputs:**
  - submitted while in GREEN, YELLOW, COMMIT or DONE.
  - Writes outside EDIT.
  - No queuing of either.
- **rowValuesFlat:** always board[currentRow]. In DONE it shows the final scored row.
- **Mid-operation reset:** clr has priority in every state. The scoring sequence is abandoned and the board cleared.

## Timing
- submitted sampled at edge T:
  - GREEN occupies cycles T+1..T+5.
  - YELLOW occupies cycles T+6..T+10.
  - COMMIT is cycle T+11.
- busy is 1 from T+1 through T+11 inclusive. It is registered, so it is 0 at T.
- Board colours, currentRow and doneGame/won update at the edge ending COMMIT, and are visible from cycle T+12.
- EDIT writes are visible on rowValuesFlat/boardFlat the cycle after the write edge.
- The answer is latched at T; later answer changes do not affect that row.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert clr for 1 cycle. Then every boardFlat entry = 7'd26, rowValuesFlat = {5{7'd26}}, currentRow=0, busy=0, doneGame=0, won=0.
- **Win on row 0:**
  - answer=CRANE (2,17,0,13,4). Drive columns 0..4 with those letters, pulsing submitted at column 4.
  - busy is high for exactly 11 cycles.
  - Row 0 = {2'b10, letter} for all 5 columns; doneGame=1, won=1, currentRow stays 0.
- **Duplicate handling:**
  - answer=APPLE, guess=PAPAL.
  - Row 0 colours are yellow, yellow, green, grey, yellow.
  - currentRow=1, doneGame=0.
- **Loss:**
  - Six non-matching guesses (e.g. ZZZZZ vs CRANE).
  - After the 6th COMMIT: doneGame=1, won=0, currentRow=5.
  - Further submitted pulses and writes leave boardFlat unchanged.
- **Busy lockout:**
  - Submit, then pulse submitted and change valueIn at T+3.
  - No second scoring pass occurs; busy falls after T+11; the row holds only the scored result.
- **Reset mid-scoring:**
  - Assert clr at T+7 (in YELLOW).
  - On the next cycle the board is all 7'd26, currentRow=0, busy=0, and the state is EDIT.
